// File: rtl/ysyx_24070014_wbu_if.sv
// Write-back unit bus: upstream entry handshake, commit handshake, GPR read ports and retire count.
// Latency: none (wires only). Slave = the WBU; master = whoever drives the entries and reads the GPRs.
// Backpressure: in_ready and out_ready carry a valid/ready handshake in each direction.
interface ysyx_24070014_wbu_if #(
    parameter int DATA_LEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic                in_wen;
    logic [4:0]          in_rd;
    logic [DATA_LEN-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [4:0]          rs1_addr;
    logic [4:0]          rs2_addr;
    logic [DATA_LEN-1:0] rs1_data;
    logic [DATA_LEN-1:0] rs2_data;
    logic [31:0]         retire_cnt;

    modport slave (
        input  in_valid, in_wen, in_rd, in_data, out_ready, rs1_addr, rs2_addr,
        output in_ready, out_valid, rs1_data, rs2_data, retire_cnt
    );

    modport master (
        output in_valid, in_wen, in_rd, in_data, out_ready, rs1_addr, rs2_addr,
        input  in_ready, out_valid, rs1_data, rs2_data, retire_cnt
    );
endinterface

// File: rtl/ysyx_24070014_wbu.sv
// Write-back unit: one-entry holding buffer in front of the GPR file, with commit counting.
// Latency: an accepted entry is held one cycle minimum, and its write lands on the commit edge; reads are combinational and bypass the held entry.
// Backpressure: in_ready = !full || out_ready, so a full buffer stalls upstream until the commit side drains it.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries in_*, out_*, rs1/rs2 read ports and retire_cnt.
module ysyx_24070014_wbu #(
    parameter int DATA_LEN = 32,
    parameter int NR_REG   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ysyx_24070014_wbu_if.slave    bus
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic                wen;
        logic [4:0]          rd;
        logic [DATA_LEN-1:0] data;
    } entry_t;

    state_e              state_q, state_d;
    entry_t              ent_q, ent_d;
    logic [31:0]         retire_cnt_q, retire_cnt_d;
    logic [DATA_LEN-1:0] regs_q [NR_REG];
    logic [DATA_LEN-1:0] regs_d [NR_REG];

    logic                full;
    logic                in_ready;
    logic                accept;
    logic                commit;
    logic                wr_en;
    logic                byp_ok;
    logic [DATA_LEN-1:0] rs1_data;
    logic [DATA_LEN-1:0] rs2_data;

    assign full     = (state_q == S_FULL);
    assign in_ready = !full || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign commit   = full && bus.out_ready;
    // Index 0 is excluded here; out-of-range indices simply match no register below.
    assign wr_en    = commit && ent_q.wen && (ent_q.rd != 5'd0);

    // Bypass only entries that will actually land in an existing register.
    assign byp_ok   = full && ent_q.wen && (ent_q.rd != 5'd0) && (int'(ent_q.rd) < NR_REG);

    always_comb begin
        state_d      = state_q;
        ent_d        = ent_q;
        retire_cnt_d = retire_cnt_q;
        unique case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (commit && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
        if (accept) begin
            ent_d.wen  = bus.in_wen;
            ent_d.rd   = bus.in_rd;
            ent_d.data = bus.in_data;
        end
        if (commit) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < NR_REG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            for (int i = 1; i < NR_REG; i++) begin
                if (5'(i) == ent_q.rd) regs_d[i] = ent_q.data;
            end
        end
    end

    // Register 0 and addresses beyond NR_REG never match the loop, so they read 0.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NR_REG; i++) begin
            if (5'(i) == bus.rs1_addr) rs1_data = regs_q[i];
            if (5'(i) == bus.rs2_addr) rs2_data = regs_q[i];
        end
        if (byp_ok && (ent_q.rd == bus.rs1_addr)) rs1_data = ent_q.data;
        if (byp_ok && (ent_q.rd == bus.rs2_addr)) rs2_data = ent_q.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            ent_q        <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NR_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ent_q        <= ent_d;
            retire_cnt_q <= retire_cnt_d;
            for (int i = 0; i < NR_REG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = full;
    assign bus.rs1_data   = rs1_data;
    assign bus.rs2_data   = rs2_data;
    assign bus.retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_ysyx_24070014_wbu.sv
// Bench for the write-back unit: scoreboard queue of accepted entries drained at commit into a GPR model.
// Inputs change 1 time unit after the rising edge; outputs are sampled once those inputs settle.
module tb_ysyx_24070014_wbu;
    logic clk;
    logic rst_n;

    ysyx_24070014_wbu_if #(.DATA_LEN(32)) bus ();

    ysyx_24070014_wbu #(.DATA_LEN(32), .NR_REG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q [$];
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    bit          m_full;
    int          checks;
    int          errors;

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt  = '0;
        m_full = 1'b0;
    endtask

    // Advance one edge, updating the model with whatever handshakes the current inputs imply.
    task automatic tick();
        bit   acc;
        bit   com;
        ent_t e;
        com = m_full && bus.out_ready;
        acc = bus.in_valid && (!m_full || bus.out_ready);
        if (com) begin
            e = exp_q.pop_front();
            if (e.wen && e.rd != 5'd0) m_regs[e.rd] = e.data;
            m_cnt = m_cnt + 32'd1;
        end
        if (acc) begin
            e.wen  = bus.in_wen;
            e.rd   = bus.in_rd;
            e.data = bus.in_data;
            exp_q.push_back(e);
            m_full = 1'b1;
        end else if (com) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic wen, input logic [4:0] rd, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_wen   = wen;
        bus.in_rd    = rd;
        bus.in_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b0;
        bus.rs1_addr  = 5'd1;
        bus.rs2_addr  = 5'd2;
        model_reset();
        #3;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL reset_rs1: got %h want 0", bus.rs1_data); end
        checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL reset_rs2: got %h want 0", bus.rs2_data); end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire: got %h want 0", bus.retire_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_write();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs1_addr = exp_q[0].rd;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.rs1_data !== exp_q[0].data) begin errors++; $display("FAIL basic_commit_data: got %h want %h", bus.rs1_data, exp_q[0].data); end
        tick();
        bus.rs1_addr = 5'd5;
        #1;
        checks++; if (bus.rs1_data !== m_regs[5]) begin errors++; $display("FAIL basic_reg5: got %h want %h", bus.rs1_data, m_regs[5]); end
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL basic_retire: got %0d want %0d", bus.retire_cnt, m_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_bypass();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd3, 32'h1234_5678);
        tick();
        // New data offered while stalled must be ignored.
        drive(1'b1, 1'b1, 5'd3, 32'hBAD0_BAD0);
        bus.rs2_addr = 5'd3;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL byp_in_ready: got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL byp_out_valid: got %b want 1", bus.out_valid); end
        checks++; if (bus.rs2_data !== exp_q[0].data) begin errors++; $display("FAIL byp_rs2: got %h want %h", bus.rs2_data, exp_q[0].data); end
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL byp_retire_hold: got %0d want %0d", bus.retire_cnt, m_cnt); end
        tick();
        checks++; if (bus.rs2_data !== exp_q[0].data) begin errors++; $display("FAIL byp_stable: got %h want %h", bus.rs2_data, exp_q[0].data); end
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.rs2_data !== m_regs[3]) begin errors++; $display("FAIL byp_reg3: got %h want %h", bus.rs2_data, m_regs[3]); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL byp_drained: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_x0_wen0();
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b0, 5'd7, 32'h0000_0055);
        bus.rs1_addr = 5'd0;
        #1;
        checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL x0_pending: got %h want 0", bus.rs1_data); end
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs2_addr = 5'd7;
        #1;
        checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL wen0_pending: got %h want 0", bus.rs2_data); end
        tick();
        checks++; if (bus.rs1_data !== m_regs[0]) begin errors++; $display("FAIL x0_reads_zero: got %h want %h", bus.rs1_data, m_regs[0]); end
        checks++; if (bus.rs2_data !== m_regs[7]) begin errors++; $display("FAIL wen0_reg7: got %h want %h", bus.rs2_data, m_regs[7]); end
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL x0_retire: got %0d want %0d", bus.retire_cnt, m_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c0;
        c0 = m_cnt;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) drive(1'b1, 1'b1, 5'(i), 32'(i) * 32'h11);
            else        drive(1'b0, 1'b0, 5'd0, 32'd0);
            if (exp_q.size() > 0) bus.rs1_addr = exp_q[0].rd;
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            if (exp_q.size() > 0) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.rs1_data !== exp_q[0].data) begin
                    errors++; $display("FAIL b2b_commit[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.out_valid, bus.rs1_data, exp_q[0].data);
                end
            end
            tick();
        end
        for (int i = 1; i <= 8; i++) begin
            bus.rs1_addr = 5'(i);
            #1;
            checks++; if (bus.rs1_data !== m_regs[i]) begin errors++; $display("FAIL b2b_reg[%0d]: got %h want %h", i, bus.rs1_data, m_regs[i]); end
        end
        checks++; if (bus.retire_cnt !== c0 + 32'd8) begin errors++; $display("FAIL b2b_retire: got %0d want %0d", bus.retire_cnt, c0 + 32'd8); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        bus.rs1_addr = 5'd9;
        bus.rs2_addr = 5'd5;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full: got %b want 1", bus.out_valid); end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.rs1_data !== 32'd0) begin errors++; $display("FAIL rst_mid_reg9: got %h want 0", bus.rs1_data); end
        checks++; if (bus.rs2_data !== 32'd0) begin errors++; $display("FAIL rst_mid_reg5: got %h want 0", bus.rs2_data); end
        checks++; if (bus.retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_mid_retire: got %0d want 0", bus.retire_cnt); end
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        tick();
        checks++; if (bus.rs1_data !== m_regs[9]) begin errors++; $display("FAIL rst_mid_discard: got %h want %h", bus.rs1_data, m_regs[9]); end
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL rst_mid_no_commit: got %0d want %0d", bus.retire_cnt, m_cnt); end
    endtask

    task automatic test_wrap();
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFF;
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL wrap_preset: got %h want %h", bus.retire_cnt, m_cnt); end
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 5'd10, 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        checks++; if (bus.retire_cnt !== m_cnt) begin errors++; $display("FAIL wrap_retire: got %h want %h", bus.retire_cnt, m_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_write();
        test_bypass();
        test_x0_wen0();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
